// File: rtl/geofence_np.sv
// Geofence engine: accepts a target point followed by NPOINT convex-polygon
// vertices, orders the vertices counter-clockwise around vertex 0 with a
// fixed-schedule bubble sort, then tests the target against every edge.
// Latency from the last accepted vertex is (NPOINT-2)^2 + NPOINT + 1 cycles.
module geofence_np #(
    parameter int NPOINT    = 6,
    parameter int W         = 11,
    parameter bit INCLUSIVE = 1'b0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [W-1:0] x,
    input  logic signed [W-1:0] y,
    output logic                out_valid,
    output logic                is_inside
);

    localparam int AW = $clog2(NPOINT);
    localparam int DW = W + 1;
    localparam int CW = 2 * W + 3;
    localparam logic [AW-1:0] LAST_CMP  = AW'(NPOINT - 3);
    localparam logic [AW-1:0] LAST_EDGE = AW'(NPOINT - 1);
    localparam logic [AW:0]   LAST_PT   = (AW + 1)'(NPOINT);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SORT  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Sign-extended difference; one extra bit keeps it exact.
    function automatic logic signed [DW-1:0] diff(input logic signed [W-1:0] a,
                                                  input logic signed [W-1:0] b);
        return DW'(a) - DW'(b);
    endfunction

    // 2-D cross product ax*by - ay*bx, wide enough to never overflow.
    function automatic logic signed [CW-1:0] cross2d(input logic signed [DW-1:0] ax,
                                                     input logic signed [DW-1:0] ay,
                                                     input logic signed [DW-1:0] bx,
                                                     input logic signed [DW-1:0] by);
        logic signed [CW-1:0] p1;
        logic signed [CW-1:0] p2;
        p1 = CW'(ax) * CW'(by);
        p2 = CW'(ay) * CW'(bx);
        return p1 - p2;
    endfunction

    state_t               state_r;
    logic [AW:0]          cnt_r;
    logic [AW-1:0]        idx_r;
    logic [AW-1:0]        pass_r;
    logic                 fail_r;
    logic signed [W-1:0]  tx_r;
    logic signed [W-1:0]  ty_r;
    logic signed [W-1:0]  rx_r [NPOINT];
    logic signed [W-1:0]  ry_r [NPOINT];

    logic [AW-1:0]        ld_s;
    logic [AW-1:0]        sa_s;
    logic [AW-1:0]        sb_s;
    logic [AW-1:0]        kn_s;
    logic signed [CW-1:0] sort_cross_s;
    logic signed [CW-1:0] edge_cross_s;
    logic                 swap_s;
    logic                 edge_fail_s;

    // Index decode plus the sort-compare and edge-test datapaths.
    always_comb begin
        ld_s = AW'(cnt_r - (AW + 1)'(1));
        sa_s = idx_r + AW'(1);
        sb_s = idx_r + AW'(2);
        if (idx_r == LAST_EDGE) begin
            kn_s = '0;
        end else begin
            kn_s = idx_r + AW'(1);
        end
        sort_cross_s = cross2d(diff(rx_r[sa_s], rx_r[0]), diff(ry_r[sa_s], ry_r[0]),
                               diff(rx_r[sb_s], rx_r[0]), diff(ry_r[sb_s], ry_r[0]));
        swap_s = sort_cross_s[CW-1];
        edge_cross_s = cross2d(diff(rx_r[kn_s], rx_r[idx_r]), diff(ry_r[kn_s], ry_r[idx_r]),
                               diff(tx_r, rx_r[idx_r]), diff(ty_r, ry_r[idx_r]));
        edge_fail_s = edge_cross_s[CW-1] | ((edge_cross_s == '0) & ~INCLUSIVE);
    end

    // Control FSM, point storage, sort swaps, fail accumulation and outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= LOAD;
            cnt_r     <= '0;
            idx_r     <= '0;
            pass_r    <= '0;
            fail_r    <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            is_inside <= 1'b0;
        end else begin
            case (state_r)
                LOAD: begin
                    out_valid <= 1'b0;
                    if (in_valid && in_ready) begin
                        if (cnt_r == '0) begin
                            tx_r <= x;
                            ty_r <= y;
                        end else begin
                            rx_r[ld_s] <= x;
                            ry_r[ld_s] <= y;
                        end
                        if (cnt_r == LAST_PT) begin
                            state_r  <= SORT;
                            in_ready <= 1'b0;
                            cnt_r    <= '0;
                            idx_r    <= '0;
                            pass_r   <= '0;
                        end else begin
                            cnt_r <= cnt_r + (AW + 1)'(1);
                        end
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                SORT: begin
                    if (swap_s) begin
                        rx_r[sa_s] <= rx_r[sb_s];
                        ry_r[sa_s] <= ry_r[sb_s];
                        rx_r[sb_s] <= rx_r[sa_s];
                        ry_r[sb_s] <= ry_r[sa_s];
                    end else begin
                        idx_r <= idx_r;
                    end
                    if (idx_r == LAST_CMP) begin
                        idx_r <= '0;
                        if (pass_r == LAST_CMP) begin
                            state_r <= CHECK;
                            fail_r  <= 1'b0;
                        end else begin
                            pass_r <= pass_r + AW'(1);
                        end
                    end else begin
                        idx_r <= idx_r + AW'(1);
                    end
                end
                CHECK: begin
                    fail_r <= fail_r | edge_fail_s;
                    if (idx_r == LAST_EDGE) begin
                        state_r   <= DONE;
                        out_valid <= 1'b1;
                        is_inside <= ~(fail_r | edge_fail_s);
                        idx_r     <= '0;
                    end else begin
                        idx_r <= idx_r + AW'(1);
                    end
                end
                DONE: begin
                    state_r   <= LOAD;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
                default: begin
                    state_r   <= LOAD;
                    cnt_r     <= '0;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_geofence_np.sv
// Directed bench for geofence_np: two hexagon engines (exclusive/inclusive
// boundary) and two full-range square engines, driven from vector tables,
// plus hand-written handshake, back-to-back and mid-sort reset sequences.
module tb_geofence_np;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst [2];
    logic              iv  [2];
    logic signed [10:0] xs [2];
    logic signed [10:0] ys [2];
    logic              rdy [4];
    logic              ov  [4];
    logic              ins [4];

    geofence_np #(.NPOINT(6), .W(11), .INCLUSIVE(1'b0)) u6_ex (
        .clk(clk), .reset(rst[0]), .in_valid(iv[0]), .in_ready(rdy[0]),
        .x(xs[0]), .y(ys[0]), .out_valid(ov[0]), .is_inside(ins[0]));
    geofence_np #(.NPOINT(6), .W(11), .INCLUSIVE(1'b1)) u6_in (
        .clk(clk), .reset(rst[0]), .in_valid(iv[0]), .in_ready(rdy[1]),
        .x(xs[0]), .y(ys[0]), .out_valid(ov[1]), .is_inside(ins[1]));
    geofence_np #(.NPOINT(4), .W(11), .INCLUSIVE(1'b0)) u4_ex (
        .clk(clk), .reset(rst[1]), .in_valid(iv[1]), .in_ready(rdy[2]),
        .x(xs[1]), .y(ys[1]), .out_valid(ov[2]), .is_inside(ins[2]));
    geofence_np #(.NPOINT(4), .W(11), .INCLUSIVE(1'b1)) u4_in (
        .clk(clk), .reset(rst[1]), .in_valid(iv[1]), .in_ready(rdy[3]),
        .x(xs[1]), .y(ys[1]), .out_valid(ov[3]), .is_inside(ins[3]));

    typedef struct {
        int tx;
        int ty;
        bit exp_ex;
        bit exp_in;
    } vec_t;

    int checks = 0;
    int errors = 0;

    int r6x [6] = '{10, -10, 5, -5, 5, -5};
    int r6y [6] = '{0, 0, 9, -9, -9, 9};
    int r4x [4] = '{-1024, 1023, 1023, -1024};
    int r4y [4] = '{-1024, 1023, -1024, 1023};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Offer one point to group g and hold it until accepted (bounded).
    task automatic push(input int g, input int px, input int py, input bit bub);
        int guard;
        if (bub) begin
            repeat ($urandom_range(0, 2)) begin
                iv[g] = 1'b0;
                xs[g] = 11'sd333;
                ys[g] = -11'sd333;
                @(negedge clk);
            end
        end
        iv[g] = 1'b1;
        xs[g] = 11'(px);
        ys[g] = 11'(py);
        guard = 0;
        while (!rdy[2*g] && guard < 60) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 60) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: in_ready never rose for group %0d", g);
        end
        @(negedge clk);
        iv[g] = 1'b0;
    endtask

    task automatic send_obj(input int g, input int tx, input int ty, input bit bub);
        push(g, tx, ty, bub);
        if (g == 0) begin
            for (int i = 0; i < 6; i++) push(g, r6x[i], r6y[i], bub);
        end else begin
            for (int i = 0; i < 4; i++) push(g, r4x[i], r4y[i], bub);
        end
    endtask

    // Send one object and check latency and both engines' results.
    task automatic run_obj(input int g, input string name, input int tx, input int ty,
                           input bit e_ex, input bit e_in, input bit bub, input bit hold);
        int cyc;
        int lat;
        bit rdy_seen;
        lat = (g == 0) ? 23 : 9;
        send_obj(g, tx, ty, bub);
        if (hold) begin
            iv[g] = 1'b1;
            xs[g] = 11'sd500;
            ys[g] = -11'sd500;
        end else begin
            iv[g] = 1'b0;
        end
        cyc = 1;
        rdy_seen = 1'b0;
        while (!ov[2*g] && cyc < 100) begin
            if (rdy[2*g]) rdy_seen = 1'b1;
            @(negedge clk);
            cyc++;
        end
        check({name, "_latency"}, cyc, lat);
        check({name, "_valid_pair"}, ov[2*g+1], 1);
        check({name, "_excl"}, ins[2*g], e_ex);
        check({name, "_incl"}, ins[2*g+1], e_in);
        check({name, "_ready_in_done"}, rdy[2*g], 0);
        if (hold) begin
            check({name, "_ready_busy"}, rdy_seen, 0);
        end else begin
            @(negedge clk);
            check({name, "_pulse_end"}, ov[2*g], 0);
            check({name, "_ready_back"}, rdy[2*g], 1);
        end
        iv[g] = 1'b0;
    endtask

    vec_t v6 [7];
    vec_t v4 [5];

    initial begin
        int seen;
        v6[0] = '{0, 0, 1'b1, 1'b1};
        v6[1] = '{20, 0, 1'b0, 1'b0};
        v6[2] = '{0, -8, 1'b1, 1'b1};
        v6[3] = '{0, 9, 1'b0, 1'b1};
        v6[4] = '{10, 0, 1'b0, 1'b1};
        v6[5] = '{8, 4, 1'b0, 1'b0};
        v6[6] = '{7, 4, 1'b1, 1'b1};
        v4[0] = '{1000, -1000, 1'b1, 1'b1};
        v4[1] = '{-1024, 0, 1'b0, 1'b1};
        v4[2] = '{-1024, -1024, 1'b0, 1'b1};
        v4[3] = '{0, 0, 1'b1, 1'b1};
        v4[4] = '{1023, 1023, 1'b0, 1'b1};

        for (int g = 0; g < 2; g++) begin
            rst[g] = 1'b1;
            iv[g]  = 1'b0;
            xs[g]  = '0;
            ys[g]  = '0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            check("reset_ready", rdy[i], 1);
            check("reset_valid", ov[i], 0);
            check("reset_inside", ins[i], 0);
        end
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++)
            run_obj(0, $sformatf("hex%0d", i), v6[i].tx, v6[i].ty, v6[i].exp_ex, v6[i].exp_in,
                    bit'(i % 2), 1'b0);
        for (int i = 0; i < 5; i++)
            run_obj(1, $sformatf("sq%0d", i), v4[i].tx, v4[i].ty, v4[i].exp_ex, v4[i].exp_in,
                    bit'(i % 2), 1'b0);

        // in_valid held high through SORT/CHECK, then a back-to-back object.
        run_obj(0, "hold", 7, 4, 1'b1, 1'b1, 1'b0, 1'b1);
        run_obj(0, "b2b", 20, 0, 1'b0, 1'b0, 1'b0, 1'b0);

        // One-cycle reset in the middle of SORT aborts the object.
        send_obj(0, 0, 0, 1'b0);
        repeat (5) @(negedge clk);
        rst[0] = 1'b1;
        @(negedge clk);
        rst[0] = 1'b0;
        check("abort_ready_ex", rdy[0], 1);
        check("abort_ready_in", rdy[1], 1);
        seen = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (ov[0] || ov[1]) seen++;
        end
        check("abort_no_valid", seen, 0);
        run_obj(0, "after_abort", 0, -8, 1'b1, 1'b1, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
